// File: rtl/proc_in_fifo.sv
// proc_in_fifo
//   Multi-channel input buffer in front of the processor input port. External
//   producers write words tagged with a channel number; each channel owns an
//   independent FIFO. The core pops words through addr_in / req_in / io_in.
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset (clears pointers, counts, sticky flags)
//   ext_wr    producer write strobe
//   ext_addr  producer target channel
//   ext_data  producer write data
//   ext_full  per-channel full flag
//   req_in    processor read (pop) strobe
//   addr_in   processor read channel
//   io_in     head word of channel addr_in, 0 when that channel is empty
//   empty     per-channel empty flag
//   ovf       sticky: a write was dropped because the channel was full
//   unf       sticky: a read was issued while the channel was empty
module proc_in_fifo #(
  parameter int NUBITS = 16,
  parameter int NBIOIN = 2,
  parameter int FDEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ext_wr,
  input  logic [NBIOIN-1:0]       ext_addr,
  input  logic [NUBITS-1:0]       ext_data,
  output logic [(2**NBIOIN)-1:0]  ext_full,
  input  logic                    req_in,
  input  logic [NBIOIN-1:0]       addr_in,
  output logic [NUBITS-1:0]       io_in,
  output logic [(2**NBIOIN)-1:0]  empty,
  output logic [(2**NBIOIN)-1:0]  ovf,
  output logic [(2**NBIOIN)-1:0]  unf
);

  localparam int NCHAN = 2 ** NBIOIN;
  localparam int AW    = $clog2(FDEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(FDEPTH);

  // Head word of every channel, selected by addr_in below.
  logic [NUBITS-1:0] head_word [NCHAN];

  for (genvar ch = 0; ch < NCHAN; ch++) begin : g_chan
    logic [NUBITS-1:0] mem [FDEPTH];
    logic [AW-1:0]     wp;
    logic [AW-1:0]     rp;
    logic [AW:0]       cnt;
    logic              ovf_r;
    logic              unf_r;
    logic              is_full;
    logic              is_empty;
    logic              wr_hit;
    logic              rd_hit;
    logic              wr_ok;
    logic              rd_ok;

    assign is_full  = (cnt == CNT_FULL);
    assign is_empty = (cnt == '0);
    assign wr_hit   = ext_wr && (ext_addr == NBIOIN'(ch));
    assign rd_hit   = req_in && (addr_in == NBIOIN'(ch));
    // Full/empty come from the pre-edge count, so a write to a full channel
    // is dropped even when the same channel is popped in this cycle.
    assign wr_ok    = wr_hit && !is_full;
    assign rd_ok    = rd_hit && !is_empty;

    always_ff @(posedge clk) begin
      if (rst) begin
        wp    <= '0;
        rp    <= '0;
        cnt   <= '0;
        ovf_r <= 1'b0;
        unf_r <= 1'b0;
      end else begin
        if (wr_ok) wp <= wp + 1'b1;
        if (rd_ok) rp <= rp + 1'b1;
        case ({wr_ok, rd_ok})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
        if (wr_hit && is_full)  ovf_r <= 1'b1;
        if (rd_hit && is_empty) unf_r <= 1'b1;
      end
    end

    // Storage is not reset; an empty channel never exposes it.
    always_ff @(posedge clk) begin
      if (wr_ok && !rst) mem[wp] <= ext_data;
    end

    assign head_word[ch] = mem[rp];
    assign ext_full[ch]  = is_full;
    assign empty[ch]     = is_empty;
    assign ovf[ch]       = ovf_r;
    assign unf[ch]       = unf_r;
  end

  assign io_in = empty[addr_in] ? '0 : head_word[addr_in];

endmodule

// File: doc/proc_in_fifo.md
# proc_in_fifo

Multi-channel input buffer that sits directly upstream of the processor's input port. It accepts words from external producers, tagged with a channel number, and stores them in one FIFO per channel. The processor pops words through its existing `addr_in` / `req_in` / `io_in` input interface. Producers and the core therefore no longer need to be cycle-aligned.

## Interface

Parameters:
- `NUBITS`, 16: data word width; equals the processor word size.
- `NBIOIN`, 2: channel address width; the block has `NCHAN = 2**NBIOIN` channels.
- `FDEPTH`, 4: words per channel FIFO; a power of two, ≥ 2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ext_wr`  in  1  producer write strobe.
- `ext_addr`  in  `NBIOIN`  target channel of the producer write.
- `ext_data`  in  `NUBITS`  producer write data.
- `ext_full`  out  `NCHAN`  per-channel full flag (bit i is channel i).
- `req_in`  in  1  processor read strobe; connects to the core's `req_in`.
- `addr_in`  in  `NBIOIN`  processor read channel; connects to the core's `addr_in`.
- `io_in`  out  `NUBITS`  read data; connects to the core's `io_in`.
- `empty`  out  `NCHAN`  per-channel empty flag.
- `ovf`  out  `NCHAN`  sticky overflow: a write was dropped on this channel.
- `unf`  out  `NCHAN`  sticky underflow: a read was issued on this channel while it was empty.

## Operation

Per-channel state:
- Storage `mem[FDEPTH]` of `NUBITS` bits.
- Write pointer `wp` and read pointer `rp`, each `log2(FDEPTH)` bits; both wrap modulo `FDEPTH`.
- Occupancy `cnt` of `log2(FDEPTH)+1` bits, range 0..`FDEPTH`.

Flags:
- `ext_full[i]` = (`cnt[i] == FDEPTH`).
- `empty[i]` = (`cnt[i] == 0`).

Write (`ext_wr`=1, `ch = ext_addr`):
- If `ext_full[ch]`=0: store `mem[ch][wp] <= ext_data`, increment `wp`, increment `cnt`.
- If `ext_full[ch]`=1: discard the word and set `ovf[ch]`. This applies even when a pop of `ch` happens in the same cycle; "full" is evaluated from the pre-edge state.

Read (`req_in`=1, `ch = addr_in`):
- If `empty[ch]`=0: increment `rp`, decrement `cnt`.
- If `empty[ch]`=1: no pointer change; set `unf[ch]`.

Read data:
- `io_in` is combinational: `mem[addr_in][rp[addr_in]]` when `empty[addr_in]`=0, otherwise 0.
- This holds whether or not `req_in` is asserted, so the core may peek.

Simultaneous write and read:
- Different channels: fully independent.
- Same channel, neither full nor empty: both take effect and `cnt` is unchanged.
- Same channel, empty: the read underflows (`io_in`=0, `unf` set) and the write is accepted. There is no bypass; the word is visible from the next cycle.
- Same channel, full: the read pops and the write is dropped with `ovf` set.

Sticky flags:
- `ovf` and `unf` are cleared only by `rst`.

Reset (`rst`=1 at a rising edge):
- All `wp`, `rp`, `cnt` go to 0, so `empty` = all ones and `ext_full` = 0.
- `ovf` = 0, `unf` = 0, and `io_in` = 0.
- Writes and reads in that cycle are ignored.
- Reset mid-transfer discards all buffered words.
- Memory contents are not cleared; they are unobservable because all channels read as empty.

## Timing

- Write-to-read latency: a word written at edge N is visible on `io_in` (and `empty` deasserts) after edge N. The earliest pop is the cycle after the write.
- A pop at edge N advances `io_in` to the next word combinationally after edge N.
- Flag update timing:
  - `ext_full` and `empty` change only on clock edges.
  - `ovf` and `unf` assert one edge after the offending strobe.
- Throughput: one write and one read per cycle, sustained on any channel mix.
- `req_in` and `ext_wr` are single-cycle strobes. Each high cycle is one operation; holding a strobe high for k cycles performs k operations.

## Test plan

1. Reset, then idle: `empty` = all ones, `ext_full` = 0, `ovf` = 0, `unf` = 0, `io_in` = 0.
2. Write 0x0011, 0x0022, 0x0033 to channel 1 on consecutive cycles, then assert `req_in` with `addr_in`=1 for 3 cycles:
   - `io_in` reads 0x0011, 0x0022, 0x0033 in order.
   - `empty[1]`=1 afterwards; other channels are untouched.
3. Fill channel 2 with 4 words (FDEPTH=4), then write a fifth (0xBEEF) in the same cycle as a pop:
   - The pop returns word 1.
   - 0xBEEF is dropped; `ovf[2]`=1 and `cnt` = 3.
   - Subsequent pops return words 2–4.
4. Read empty channel 0 while writing 0x1234 to channel 0 in the same cycle:
   - `io_in`=0 and `unf[0]`=1.
   - The next cycle shows `io_in`=0x1234 with `addr_in`=0.
5. Wrap-around: on channel 3, interleave 10 writes and 10 reads, one each per cycle, with data 1..10:
   - Output sequence is 1..10.
   - `cnt` never exceeds 1.
6. Reset mid-operation: channel 1 holds 2 words and `ovf[2]` is set; assert `rst` for one cycle. All flags return to reset values, and a following read of channel 1 returns 0 with `unf[1]`=1.
